// File: rtl/dma_engineer_arbiter.sv
// ---------------------------------------------------------------------------
// dma_engineer_arbiter
//
// Shares one DMA weight-fetch engine between N_REQ layer controllers. Each
// layer keeps its own req/ack/start_addr/length/dout_en/dout_eop interface.
// Layers are granted one at a time in round-robin order. The winner's request
// is latched and forwarded to the engine. The returned beat stream is routed
// to the granted layer until end-of-packet, and then the next layer is granted.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   lyr_req[N_REQ]            per-layer request (level, held until ack)
//   lyr_start_addr, lyr_length  per-layer request fields, layer i at
//                             [i*ADDR_W +: ADDR_W]
//   lyr_ack[N_REQ]            one-cycle ack pulse to the granted layer
//   lyr_dout_en/eop[N_REQ]    beat valid / last beat, granted layer only
//   lyr_dout                  beat data, broadcast to all layers
//   dma_engineer_*            engine-side request/ack and beat stream
//   busy                      high whenever a grant is active (not IDLE)
//   grant_idx                 current or last winner
//   err_stray                 sticky: beat seen while no grant was active
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dma_engineer_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 27,
    parameter int DATA_W = 512,
    parameter int IDX_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,   // active low
    input  logic [N_REQ-1:0]          lyr_req,
    input  logic [N_REQ*ADDR_W-1:0]   lyr_start_addr,
    input  logic [N_REQ*ADDR_W-1:0]   lyr_length,
    output logic [N_REQ-1:0]          lyr_ack,
    output logic [N_REQ-1:0]          lyr_dout_en,
    output logic [N_REQ-1:0]          lyr_dout_eop,
    output logic [DATA_W-1:0]         lyr_dout,
    output logic                      dma_engineer_req,
    input  logic                      dma_engineer_ack,
    output logic [ADDR_W-1:0]         dma_engineer_start_addr,
    output logic [ADDR_W-1:0]         dma_engineer_length,
    input  logic                      dma_engineer_dout_en,
    input  logic                      dma_engineer_dout_eop,
    input  logic [DATA_W-1:0]         dma_engineer_dout,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      err_stray
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                err_q, err_d;

    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [ADDR_W-1:0]   win_len;
    logic [N_REQ-1:0]    grant_oh;
    logic [IDX_W-1:0]    rr_next;

    // Round-robin search: first set request scanning upward from rr_ptr,
    // wrapping modulo N_REQ. Only indices below N_REQ are ever visited.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no inferred latch).
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_valid && (j == idx) && lyr_req[j]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
        end
    end

    // Winner's request fields and the one-hot decode of the active grant.
    always_comb begin
        win_addr = '0;
        win_len  = '0;
        grant_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (IDX_W'(j) == win_idx) begin
                win_addr = lyr_start_addr[j*ADDR_W +: ADDR_W];
                win_len  = lyr_length[j*ADDR_W +: ADDR_W];
            end
            grant_oh[j] = (IDX_W'(j) == grant_idx_q);
        end
    end

    assign rr_next = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                        : grant_idx_q + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        req_d       = req_q;
        addr_d      = addr_q;
        len_d       = len_q;
        ack_d       = '0;
        // A beat with no active grant has nowhere to go; remember it.
        err_d       = err_q | (dma_engineer_dout_en & (state_q == ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d     = ST_REQ;
                    grant_idx_d = win_idx;
                    addr_d      = win_addr;
                    len_d       = win_len;
                    req_d       = 1'b1;
                end
            end
            ST_REQ: begin
                if (dma_engineer_ack) begin
                    req_d = 1'b0;
                    ack_d = grant_oh;
                    // Single-beat packet finishing in the ack cycle skips XFER.
                    if (dma_engineer_dout_eop) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = rr_next;
                    end else begin
                        state_d  = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (dma_engineer_dout_en && dma_engineer_dout_eop) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: registered handshake, combinational beat routing.
    always_comb begin
        busy                    = (state_q != ST_IDLE);
        grant_idx               = grant_idx_q;
        dma_engineer_req        = req_q;
        dma_engineer_start_addr = addr_q;
        dma_engineer_length     = len_q;
        lyr_ack                 = ack_q;
        err_stray               = err_q;
        lyr_dout                = dma_engineer_dout;
        lyr_dout_en             = grant_oh & {N_REQ{dma_engineer_dout_en  & busy}};
        lyr_dout_eop            = grant_oh & {N_REQ{dma_engineer_dout_eop & busy}};
    end

endmodule

// File: tb/tb_dma_engineer_arbiter.sv
`timescale 1ns/1ps

module tb_dma_engineer_arbiter;

    localparam int N  = 4;
    localparam int AW = 27;
    localparam int DW = 512;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    lyr_req;
    logic [N*AW-1:0] lyr_start_addr;
    logic [N*AW-1:0] lyr_length;
    logic [N-1:0]    lyr_ack;
    logic [N-1:0]    lyr_dout_en;
    logic [N-1:0]    lyr_dout_eop;
    logic [DW-1:0]   lyr_dout;
    logic            dma_req;
    logic            dma_ack;
    logic [AW-1:0]   dma_addr;
    logic [AW-1:0]   dma_len;
    logic            dma_en;
    logic            dma_eop;
    logic [DW-1:0]   dma_dout;
    logic            busy;
    logic [IW-1:0]   grant_idx;
    logic            err_stray;

    dma_engineer_arbiter #(
        .N_REQ (N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .IDX_W (IW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .lyr_req                (lyr_req),
        .lyr_start_addr         (lyr_start_addr),
        .lyr_length             (lyr_length),
        .lyr_ack                (lyr_ack),
        .lyr_dout_en            (lyr_dout_en),
        .lyr_dout_eop           (lyr_dout_eop),
        .lyr_dout               (lyr_dout),
        .dma_engineer_req       (dma_req),
        .dma_engineer_ack       (dma_ack),
        .dma_engineer_start_addr(dma_addr),
        .dma_engineer_length    (dma_len),
        .dma_engineer_dout_en   (dma_en),
        .dma_engineer_dout_eop  (dma_eop),
        .dma_engineer_dout      (dma_dout),
        .busy                   (busy),
        .grant_idx              (grant_idx),
        .err_stray              (err_stray)
    );

    always #5 clk = ~clk;

    typedef enum int {DROP_NONE, DROP_IN_REQ, DROP_AT_ACK} drop_e;

    typedef struct {
        logic [N-1:0]  mask;
        int            beats;
        bit            shortcut;
        drop_e         drop;
        logic [IW-1:0] exp_idx;
    } vec_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
    } grant_t;

    logic [AW-1:0] addr_tab [N];
    logic [AW-1:0] len_tab  [N];
    vec_t          vecs     [12];
    grant_t        sb_q     [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) begin
            d[w*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    task automatic push_expect(input logic [IW-1:0] idx);
        grant_t g;
        g.idx  = idx;
        g.addr = addr_tab[idx];
        g.len  = len_tab[idx];
        sb_q.push_back(g);
    endtask

    // Waits (bounded) for the engine request; returns negedges waited.
    task automatic wait_req(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!dma_req && cycles < 50);
        if (!dma_req) check("engine_req_timeout", dma_req, 1'b1);
    endtask

    // Engine model for one granted transfer. Entered at the negedge where
    // dma_req is first seen; returns at a negedge with the arbiter in IDLE.
    task automatic do_transfer(input vec_t v);
        grant_t        g;
        logic [N-1:0]  oh;
        logic [DW-1:0] d;
        oh        = '0;
        oh[v.exp_idx] = 1'b1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", sb_q.size(), 1);
            return;
        end
        g = sb_q.pop_front();
        check("grant_idx", grant_idx, g.idx);
        check("engine_addr", dma_addr, g.addr);
        check("engine_len", dma_len, g.len);
        check("busy_in_req", busy, 1'b1);
        check("ack_before_engine_ack", lyr_ack, '0);

        if (v.drop == DROP_IN_REQ) begin
            lyr_req = '0;
            @(negedge clk);
            check("req_held_after_drop", dma_req, 1'b1);
            check("addr_held_after_drop", dma_addr, g.addr);
            check("grant_held_after_drop", grant_idx, g.idx);
        end

        dma_ack = 1'b1;
        if (v.shortcut) begin
            d        = rand_beat();
            dma_dout = d;
            dma_en   = 1'b1;
            dma_eop  = 1'b1;
            #1;
            check("shortcut_dout_en", lyr_dout_en, oh);
            check("shortcut_dout_eop", lyr_dout_eop, oh);
            check("shortcut_dout", lyr_dout, d);
        end
        @(negedge clk);
        dma_ack = 1'b0;
        dma_en  = 1'b0;
        dma_eop = 1'b0;
        check("lyr_ack_pulse", lyr_ack, oh);
        check("engine_req_dropped", dma_req, 1'b0);
        if (v.drop == DROP_AT_ACK) lyr_req = '0;

        if (v.shortcut) begin
            check("shortcut_idle", busy, 1'b0);
        end else begin
            check("busy_in_xfer", busy, 1'b1);
            for (int b = 0; b < v.beats; b++) begin
                if (b > 0) @(negedge clk);
                d        = rand_beat();
                dma_dout = d;
                dma_en   = 1'b1;
                dma_eop  = (b == v.beats - 1);
                #1;
                check("beat_dout_en", lyr_dout_en, oh);
                check("beat_dout_eop", lyr_dout_eop, (b == v.beats - 1) ? oh : '0);
                check("beat_dout", lyr_dout, d);
                check("engine_req_low_xfer", dma_req, 1'b0);
            end
            @(negedge clk);
            dma_en  = 1'b0;
            dma_eop = 1'b0;
            check("idle_after_eop", busy, 1'b0);
            check("lyr_ack_one_cycle", lyr_ack, '0);
        end

        if (v.drop != DROP_NONE) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check("no_regrant", busy, 1'b0);
            end
        end
    endtask

    initial begin
        int cyc;
        vec_t v;

        addr_tab = '{27'd100, 27'd200, 27'd1824, 27'h7FF_FFFF};
        len_tab  = '{27'd5, 27'd6, 27'd1, 27'd0};
        //           mask     beats shortcut drop         winner
        vecs[0]  = '{4'b1011, 3, 1'b0, DROP_NONE,   2'd0};
        vecs[1]  = '{4'b1011, 3, 1'b0, DROP_NONE,   2'd1};
        vecs[2]  = '{4'b1011, 3, 1'b0, DROP_NONE,   2'd3};
        vecs[3]  = '{4'b1011, 3, 1'b0, DROP_NONE,   2'd0};
        vecs[4]  = '{4'b1011, 3, 1'b0, DROP_NONE,   2'd1};
        vecs[5]  = '{4'b1011, 3, 1'b0, DROP_AT_ACK, 2'd3};
        vecs[6]  = '{4'b0100, 1, 1'b0, DROP_AT_ACK, 2'd2};
        vecs[7]  = '{4'b0010, 1, 1'b1, DROP_AT_ACK, 2'd1};
        vecs[8]  = '{4'b0110, 2, 1'b0, DROP_AT_ACK, 2'd2};
        vecs[9]  = '{4'b0001, 2, 1'b0, DROP_IN_REQ, 2'd0};
        vecs[10] = '{4'b0011, 1, 1'b0, DROP_AT_ACK, 2'd1};
        vecs[11] = '{4'b1111, 1, 1'b1, DROP_AT_ACK, 2'd2};

        for (int i = 0; i < N; i++) begin
            lyr_start_addr[i*AW +: AW] = addr_tab[i];
            lyr_length[i*AW +: AW]     = len_tab[i];
        end
        rst      = 1'b0;
        lyr_req  = '0;
        dma_ack  = 1'b0;
        dma_en   = 1'b0;
        dma_eop  = 1'b0;
        dma_dout = '0;

        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_engine_req", dma_req, 1'b0);
        check("rst_grant_idx", grant_idx, '0);
        check("rst_addr", dma_addr, '0);
        check("rst_len", dma_len, '0);
        check("rst_lyr_ack", lyr_ack, '0);
        check("rst_err_stray", err_stray, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            push_expect(vecs[i].exp_idx);
            lyr_req = vecs[i].mask;
            wait_req(cyc);
            check("req_latency", cyc, 1);
            do_transfer(vecs[i]);
        end

        // Stray beat while IDLE: not routed, sticky error flag.
        check("err_stray_clear", err_stray, 1'b0);
        dma_dout = rand_beat();
        dma_en   = 1'b1;
        dma_eop  = 1'b1;
        #1;
        check("stray_dout_en", lyr_dout_en, '0);
        check("stray_dout_eop", lyr_dout_eop, '0);
        @(negedge clk);
        dma_en  = 1'b0;
        dma_eop = 1'b0;
        check("err_stray_set", err_stray, 1'b1);
        repeat (3) @(negedge clk);
        check("err_stray_sticky", err_stray, 1'b1);
        check("stray_no_grant", busy, 1'b0);

        // Reset in the middle of a 4-beat transfer after 2 beats.
        push_expect(2'd2);
        lyr_req = 4'b0100;
        wait_req(cyc);
        begin
            grant_t g;
            g = sb_q.pop_front();
            check("mid_rst_grant", grant_idx, g.idx);
        end
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        lyr_req = '0;
        check("mid_rst_ack", lyr_ack, 4'b0100);
        for (int b = 0; b < 2; b++) begin
            dma_dout = rand_beat();
            dma_en   = 1'b1;
            #1;
            check("mid_rst_beat", lyr_dout_en, 4'b0100);
            @(negedge clk);
        end
        dma_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_dout_en", lyr_dout_en, '0);
        check("arst_engine_req", dma_req, 1'b0);
        check("arst_grant_idx", grant_idx, '0);
        check("arst_addr", dma_addr, '0);
        check("arst_len", dma_len, '0);
        check("arst_err_stray", err_stray, 1'b0);
        dma_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        v = '{4'b1001, 1, 1'b0, DROP_AT_ACK, 2'd0};
        push_expect(v.exp_idx);
        lyr_req = v.mask;
        wait_req(cyc);
        check("post_rst_latency", cyc, 1);
        do_transfer(v);

        v = '{4'b1000, 2, 1'b0, DROP_AT_ACK, 2'd3};
        push_expect(v.exp_idx);
        lyr_req = v.mask;
        wait_req(cyc);
        check("layer3_latency", cyc, 1);
        do_transfer(v);

        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
